// File: rtl/adapt_scheduler.sv
// adapt_scheduler: STARTUP->CMA->LMS->TRACK equalizer adaptation sequencer with programmable phase lengths.
// Optional high-error fallback to CMA is built when ADAPT_FALLBACK_EN is defined.
module adapt_scheduler #(
  parameter int CNT_W        = 32,
  parameter int MU_W         = 8,
  parameter int FALLBACK_LEN = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             restart,
  input  logic [CNT_W-1:0] startup_delay,
  input  logic [CNT_W-1:0] cma_duration,
  input  logic [CNT_W-1:0] lms_duration,
  input  logic [MU_W-1:0]  mu_cma,
  input  logic [MU_W-1:0]  mu_lms,
  input  logic [MU_W-1:0]  mu_track,
  input  logic             err_high,
  output logic [1:0]       adaptation_phase,
  output logic [CNT_W-1:0] iteration_count,
  output logic [MU_W-1:0]  mu,
  output logic             adapt_on,
  output logic             phase_change,
  output logic [7:0]       fallback_count
);
  typedef enum logic [1:0] {STARTUP, CMA, LMS, TRACK} phase_t;
  phase_t           phase, phase_nxt;
  logic [CNT_W-1:0] pc, dur, lim;
  logic [MU_W-1:0]  mu_nxt;
  logic             fb, moved;
  assign adaptation_phase = phase;
  assign iteration_count  = pc;
`ifdef ADAPT_FALLBACK_EN
  logic [CNT_W-1:0] ec;
  logic [7:0]       fc;
  assign fallback_count = fc;
  assign fb = enable && err_high && (phase == LMS || phase == TRACK) && ec >= CNT_W'(FALLBACK_LEN - 1);
  // Consecutive high-error counter and saturating fallback tally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ec <= '0;
      fc <= '0;
    end else begin
      ec <= (restart || moved || (enable && !err_high)) ? '0 :
            (enable && (phase == LMS || phase == TRACK)) ? ec + 1'b1 : ec;
      fc <= (fb && !restart && fc != 8'hff) ? fc + 1'b1 : fc;
    end
  end
`else
  logic unused_fallback;
  assign unused_fallback = err_high ^ (FALLBACK_LEN == 0);
  assign fallback_count  = '0;
  assign fb              = 1'b0;
`endif
  // Next phase from live durations; a zero duration behaves as one cycle
  always_comb begin
    dur       = phase == STARTUP ? startup_delay : phase == CMA ? cma_duration : lms_duration;
    lim       = dur == '0 ? '0 : dur - 1'b1;
    phase_nxt = restart ? STARTUP :
                fb ? CMA :
                (enable && phase != TRACK && pc >= lim) ? phase_t'(phase + 2'd1) : phase;
    moved     = phase_nxt != phase;
    mu_nxt    = phase_nxt == CMA ? mu_cma : phase_nxt == LMS ? mu_lms :
                phase_nxt == TRACK ? mu_track : '0;
  end
  // Phase register, phase counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase        <= STARTUP;
      pc           <= '0;
      mu           <= '0;
      adapt_on     <= 1'b0;
      phase_change <= 1'b0;
    end else begin
      phase        <= phase_nxt;
      pc           <= (restart || moved) ? '0 : (enable && !(&pc)) ? pc + 1'b1 : pc;
      mu           <= mu_nxt;
      adapt_on     <= phase_nxt != STARTUP;
      phase_change <= moved;
    end
  end
endmodule

// File: tb/tb_adapt_scheduler.sv
// tb_adapt_scheduler: table, directed and randomized checks of adapt_scheduler against a reference model.
module tb_adapt_scheduler;
  localparam int CW = 16;
  localparam int MW = 8;
  localparam int FL = 8;
`ifdef ADAPT_FALLBACK_EN
  localparam bit FB = 1'b1;
`else
  localparam bit FB = 1'b0;
`endif
  logic          clk = 1'b0, rst_n = 1'b0, enable = 1'b0, restart = 1'b0, err_high = 1'b0;
  logic [CW-1:0] startup_delay = '0, cma_duration = '0, lms_duration = '0;
  logic [MW-1:0] mu_cma = 8'd11, mu_lms = 8'd22, mu_track = 8'd33;
  logic [1:0]    adaptation_phase;
  logic [CW-1:0] iteration_count;
  logic [MW-1:0] mu;
  logic          adapt_on, phase_change;
  logic [7:0]    fallback_count;

  adapt_scheduler #(.CNT_W(CW), .MU_W(MW), .FALLBACK_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
    .startup_delay(startup_delay), .cma_duration(cma_duration), .lms_duration(lms_duration),
    .mu_cma(mu_cma), .mu_lms(mu_lms), .mu_track(mu_track), .err_high(err_high),
    .adaptation_phase(adaptation_phase), .iteration_count(iteration_count), .mu(mu),
    .adapt_on(adapt_on), .phase_change(phase_change), .fallback_count(fallback_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int m_phase, m_pc, m_ec, m_fc, m_chg;

  typedef struct {
    bit en;
    bit rs;
    int ph;
    int ic;
    int chg;
    int mu;
  } vec_t;
  vec_t tbl[10];

  function automatic int mu_of(int p);
    return p == 1 ? int'(mu_cma) : p == 2 ? int'(mu_lms) : p == 3 ? int'(mu_track) : 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_pc = 0; m_ec = 0; m_fc = 0; m_chg = 0;
  endtask

  // Phase length in enabled cycles; each phase lasts at least one enabled cycle
  task automatic model_step();
    int d, np;
    bit fbk;
    d   = m_phase == 0 ? int'(startup_delay) : m_phase == 1 ? int'(cma_duration) : int'(lms_duration);
    if (d == 0) d = 1;
    fbk = FB && enable && err_high && m_phase >= 2 && m_ec + 1 >= FL;
    if (restart) np = 0;
    else if (fbk) np = 1;
    else if (enable && m_phase < 3 && m_pc + 1 >= d) np = m_phase + 1;
    else np = m_phase;
    if (FB) begin
      if (restart || np != m_phase || (enable && !err_high)) m_ec = 0;
      else if (enable && m_phase >= 2) m_ec++;
      if (fbk && !restart && m_fc < 255) m_fc++;
    end
    if (restart || np != m_phase) m_pc = 0;
    else if (enable && m_pc < (1 << CW) - 1) m_pc++;
    m_chg   = int'(np != m_phase);
    m_phase = np;
  endtask

  task automatic chk(string tag, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_model(string tag);
    n_vec++;
    if (int'(adaptation_phase) != m_phase || int'(iteration_count) != m_pc || int'(mu) != mu_of(m_phase) ||
        adapt_on != (m_phase != 0) || int'(phase_change) != m_chg || int'(fallback_count) != m_fc) begin
      n_err++;
      $display("FAIL %s @%0t: got ph=%0d ic=%0d mu=%0d on=%0d chg=%0d fc=%0d expected ph=%0d ic=%0d mu=%0d on=%0d chg=%0d fc=%0d",
               tag, $time, adaptation_phase, iteration_count, mu, adapt_on, phase_change, fallback_count,
               m_phase, m_pc, mu_of(m_phase), m_phase != 0, m_chg, m_fc);
    end
  endtask

  task automatic tick(string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset(string tag);
    rst_n = 1'b0;
    #2;
    chk({tag, "_phase"}, int'(adaptation_phase), 0);
    chk({tag, "_ic"}, int'(iteration_count), 0);
    chk({tag, "_outs"}, int'({mu, adapt_on, phase_change, fallback_count}), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #3;
    do_reset("reset");

    // Plan 1: durations 4/10/20 with enable held high
    startup_delay = 4; cma_duration = 10; lms_duration = 20; enable = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick("seq_const");
      if (k == 3)  chk("still_startup_e3", int'(adaptation_phase), 0);
      if (k == 4)  chk("cma_e4", int'({adaptation_phase, phase_change}), 3);
      if (k == 13) chk("still_cma_e13", int'(adaptation_phase), 1);
      if (k == 14) chk("lms_e14", int'({adaptation_phase, phase_change, mu}), (5 << 8) | 22);
      if (k == 34) chk("track_e34", int'({adaptation_phase, phase_change, mu}), (7 << 8) | 33);
      if (k == 35) chk("chg_drop_e35", int'(phase_change), 0);
    end

    // Plan 2: enable toggling every other clock, startup_delay=3
    do_reset("reset2");
    startup_delay = 3;
    for (int k = 1; k <= 8; k++) begin
      enable = (k % 2 == 0);
      tick("seq_toggle");
      if (k == 3) chk("frozen_ic_k3", int'(iteration_count), 1);
      if (k == 5) chk("startup_k5", int'(adaptation_phase), 0);
      if (k == 6) chk("cma_k6", int'(adaptation_phase), 1);
    end

    // Table: all durations zero with enable and restart patterns
    tbl[0] = '{0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 1, 0, 1, 11};
    tbl[2] = '{0, 0, 1, 0, 0, 11};
    tbl[3] = '{1, 0, 2, 0, 1, 22};
    tbl[4] = '{1, 0, 3, 0, 1, 33};
    tbl[5] = '{1, 0, 3, 1, 0, 33};
    tbl[6] = '{1, 0, 3, 2, 0, 33};
    tbl[7] = '{0, 1, 0, 0, 1, 0};
    tbl[8] = '{0, 0, 0, 0, 0, 0};
    tbl[9] = '{1, 0, 1, 0, 1, 11};
    do_reset("reset3");
    startup_delay = 0; cma_duration = 0; lms_duration = 0;
    for (int i = 0; i < 10; i++) begin
      enable = tbl[i].en; restart = tbl[i].rs;
      tick("tbl_model");
      chk($sformatf("tbl%0d_phase", i), int'(adaptation_phase), tbl[i].ph);
      chk($sformatf("tbl%0d_ic", i), int'(iteration_count), tbl[i].ic);
      chk($sformatf("tbl%0d_chg", i), int'(phase_change), tbl[i].chg);
      chk($sformatf("tbl%0d_mu", i), int'(mu), tbl[i].mu);
    end
    restart = 1'b0;

    // Restart in LMS while enable is low
    do_reset("reset4");
    startup_delay = 1; cma_duration = 1; lms_duration = 100; enable = 1'b1;
    repeat (3) tick("to_lms");
    chk("in_lms", int'(adaptation_phase), 2);
    enable = 1'b0; restart = 1'b1;
    tick("restart_lms");
    chk("restart_outs", int'({adaptation_phase, mu, adapt_on, phase_change}), 1);
    restart = 1'b0;
    tick("restart_after");
    chk("restart_chg_drop", int'(phase_change), 0);

`ifdef ADAPT_FALLBACK_EN
    // Fallback from TRACK: 7 high, 1 low, then 8 high
    do_reset("reset5");
    startup_delay = 1; cma_duration = 1; lms_duration = 1; enable = 1'b1;
    repeat (3) tick("to_track");
    chk("in_track", int'(adaptation_phase), 3);
    err_high = 1'b1;
    repeat (7) tick("burst1");
    chk("no_fb_burst1", int'(adaptation_phase), 3);
    err_high = 1'b0;
    tick("err_low");
    err_high = 1'b1;
    repeat (7) tick("burst2");
    chk("no_fb_yet", int'(adaptation_phase), 3);
    tick("burst2_last");
    chk("fb_phase", int'(adaptation_phase), 1);
    chk("fb_count", int'(fallback_count), 1);
    chk("fb_ic", int'(iteration_count), 0);
    chk("fb_chg", int'(phase_change), 1);
    // Restart coinciding with the fallback condition in LMS
    err_high = 1'b0; lms_duration = 100;
    tick("to_lms2");
    chk("in_lms2", int'(adaptation_phase), 2);
    err_high = 1'b1;
    repeat (7) tick("burst3");
    restart = 1'b1;
    tick("restart_vs_fb");
    chk("rvf_phase", int'(adaptation_phase), 0);
    chk("rvf_count", int'(fallback_count), 1);
    restart = 1'b0; err_high = 1'b0;
`endif

    // Asynchronous reset in the middle of CMA
    do_reset("reset6");
    startup_delay = 2; cma_duration = 50; enable = 1'b1;
    repeat (5) tick("to_cma");
    chk("in_cma", int'(adaptation_phase), 1);
    do_reset("async_mid_cma");
    repeat (3) tick("after_async");
    chk("restart_seq", int'(adaptation_phase), 1);

    // Randomized traffic with live duration changes
    do_reset("reset7");
    for (int k = 0; k < 3000; k++) begin
      if (k % 150 == 0) begin
        startup_delay = CW'($urandom_range(0, 6));
        cma_duration  = CW'($urandom_range(0, 12));
        lms_duration  = CW'($urandom_range(0, 30));
      end
      enable   = ($urandom % 4) != 0;
      err_high = ($urandom % 8) != 0;
      restart  = ($urandom % 200) == 0;
      tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
